// File: rtl/cache_line_ctrl_pkg.sv
// Shared types and sizing helpers for the multi-beat line-fill cache controller.
package cache_line_ctrl_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RESP  = 2'd2,
    WRITE = 2'd3
  } state_t;

  function automatic int beat_words(input int sram_dw);
    return sram_dw / WORD_W;
  endfunction

  function automatic int beats(input int line_words, input int sram_dw);
    return line_words / beat_words(sram_dw);
  endfunction

  // Byte-offset bits inside one line.
  function automatic int line_off_bits(input int line_words);
    return $clog2(line_words * (WORD_W / 8));
  endfunction

  function automatic int word_idx_w(input int line_words);
    return (line_words > 1) ? $clog2(line_words) : 1;
  endfunction

  function automatic int beat_idx_w(input int line_words, input int sram_dw);
    int n;
    n = beats(line_words, sram_dw);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cache_line_ctrl_fill_seq.sv
// Line-fill sequencer: beat counter, per-beat SRAM address, last-beat detect and
// capture of the requested word out of the beat that carries it.
module cache_fill_seq
  import cache_line_ctrl_pkg::*;
#(
  parameter int LINE_WORDS = 2,
  parameter int SRAM_DW    = 64,
  localparam int BEAT_W    = beat_idx_w(LINE_WORDS, SRAM_DW),
  localparam int WIDX_W    = word_idx_w(LINE_WORDS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_clear,
  input  logic                i_advance,
  input  logic [31:0]         i_line_base,
  input  logic [WIDX_W-1:0]   i_word_idx,
  input  logic [SRAM_DW-1:0]  i_sram_rdata,
  output logic [BEAT_W-1:0]   o_beat,
  output logic [31:0]         o_beat_addr,
  output logic                o_last,
  output logic [WORD_W-1:0]   o_word
);

  localparam int                BEAT_WORDS = beat_words(SRAM_DW);
  localparam int                BEATS      = beats(LINE_WORDS, SRAM_DW);
  localparam int                LANE_SH    = $clog2(BEAT_WORDS);
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEATS - 1);
  localparam logic [31:0]       BEAT_BYTES = 32'(SRAM_DW / 8);
  localparam logic [31:0]       LANE_MASK  = 32'(BEAT_WORDS - 1);

  logic [BEAT_W-1:0] r_beat;
  logic [WORD_W-1:0] r_word;
  logic [31:0]       w_widx;
  logic [31:0]       w_tgt_beat;
  logic [31:0]       w_lane;
  logic [WORD_W-1:0] w_lane_word;
  logic              w_capture;

  assign w_widx     = 32'(i_word_idx);
  assign w_tgt_beat = w_widx >> LANE_SH;
  assign w_lane     = w_widx & LANE_MASK;
  assign w_capture  = i_advance && (w_tgt_beat == 32'(r_beat));

  always_comb begin
    w_lane_word = '0;
    for (int k = 0; k < BEAT_WORDS; k++) begin
      if (w_lane == 32'(k)) w_lane_word = i_sram_rdata[k*WORD_W +: WORD_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat <= '0;
      r_word <= '0;
    end else begin
      if (i_clear) r_beat <= '0;
      else if (i_advance) r_beat <= o_last ? '0 : r_beat + BEAT_W'(1);
      if (w_capture) r_word <= w_lane_word;
    end
  end

  assign o_beat      = r_beat;
  assign o_last      = (r_beat == LAST_BEAT);
  assign o_beat_addr = i_line_base + 32'(r_beat) * BEAT_BYTES;
  assign o_word      = r_word;

endmodule

// File: rtl/cache_line_ctrl.sv
// Read-allocate, write-through/write-update cache controller with multi-beat line fill.
// Optional hit/miss statistics are built only when CACHE_STATS_EN is defined.
//
// state | meaning
// IDLE  | lookup; serve read hits and idle cycles with ready
// FILL  | fetch line beats from SRAM, writing each into the cache
// RESP  | return the captured word for the missed load
// WRITE | store goes through to SRAM
module cache_line_ctrl
  import cache_line_ctrl_pkg::*;
#(
  parameter int unsigned BASE_ADDR  = 1024,
  parameter int          CACHE_AW   = 17,
  parameter int          SRAM_DW    = 64,
  parameter int          LINE_WORDS = 2,
  localparam int         BEAT_W     = beat_idx_w(LINE_WORDS, SRAM_DW)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         address,
  input  logic [31:0]         wdata,
  input  logic                mem_r_en,
  input  logic                mem_w_en,
  output logic [31:0]         rdata,
  output logic                ready,
  input  logic                sram_ready,
  input  logic [SRAM_DW-1:0]  sram_rdata,
  output logic [31:0]         sram_address,
  output logic [31:0]         sram_wdata,
  output logic                sram_r_en,
  output logic                sram_w_en,
  input  logic                cache_hit,
  input  logic [31:0]         cache_rdata,
  output logic [CACHE_AW-1:0] cache_address,
  output logic                cache_r_en,
  output logic                cache_w_en,
  output logic [31:0]         cache_wdata,
  output logic                cache_fill_en,
  output logic [BEAT_W-1:0]   cache_fill_beat,
  output logic                cache_fill_last,
  output logic [SRAM_DW-1:0]  cache_fill_data,
  output logic [31:0]         hit_cnt,
  output logic [31:0]         miss_cnt
);

  localparam int          LOB       = line_off_bits(LINE_WORDS);
  localparam int          WIDX_W    = word_idx_w(LINE_WORDS);
  localparam logic [31:0] LINE_MASK = ~32'(LINE_WORDS * 4 - 1);
  localparam logic [31:0] BASE_W    = 32'(BASE_ADDR >> 2);

  state_t              r_state;
  state_t              w_next;
  logic [31:0]         w_line_base;
  logic [WIDX_W-1:0]   w_word_idx;
  logic [BEAT_W-1:0]   w_beat;
  logic [31:0]         w_beat_addr;
  logic                w_last;
  logic [WORD_W-1:0]   w_word;
  logic                w_fill_start;
  logic                w_advance;

  // BASE_ADDR is line-aligned, so the low offset bits equal the address bits.
  assign w_line_base   = address & LINE_MASK;
  assign cache_address = address[CACHE_AW+1:2] - BASE_W[CACHE_AW-1:0];

  if (LINE_WORDS > 1) begin : g_widx
    assign w_word_idx = address[LOB-1:2];
  end else begin : g_widx_single
    assign w_word_idx = '0;
  end

  cache_fill_seq #(
    .LINE_WORDS (LINE_WORDS),
    .SRAM_DW    (SRAM_DW)
  ) u_fill_seq (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_fill_start),
    .i_advance    (w_advance),
    .i_line_base  (w_line_base),
    .i_word_idx   (w_word_idx),
    .i_sram_rdata (sram_rdata),
    .o_beat       (w_beat),
    .o_beat_addr  (w_beat_addr),
    .o_last       (w_last),
    .o_word       (w_word)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next          = r_state;
    rdata           = '0;
    ready           = 1'b0;
    sram_address    = '0;
    sram_wdata      = '0;
    sram_r_en       = 1'b0;
    sram_w_en       = 1'b0;
    cache_r_en      = 1'b0;
    cache_w_en      = 1'b0;
    cache_wdata     = '0;
    cache_fill_en   = 1'b0;
    cache_fill_beat = '0;
    cache_fill_last = 1'b0;
    cache_fill_data = '0;
    w_fill_start    = 1'b0;
    w_advance       = 1'b0;
    case (r_state)
      IDLE: begin
        cache_r_en = 1'b1;
        if (mem_r_en) begin
          if (cache_hit) begin
            rdata = cache_rdata;
            ready = 1'b1;
          end else begin
            w_next       = FILL;
            w_fill_start = 1'b1;
          end
        end else if (mem_w_en) begin
          w_next = WRITE;
          if (cache_hit) begin
            cache_w_en  = 1'b1;
            cache_wdata = wdata;
          end
        end else begin
          ready = 1'b1;
        end
      end
      FILL: begin
        sram_r_en    = 1'b1;
        sram_address = w_beat_addr;
        // A beat landing with reset is dropped so an aborted line never validates.
        if (sram_ready && !rst) begin
          cache_fill_en   = 1'b1;
          cache_fill_beat = w_beat;
          cache_fill_data = sram_rdata;
          w_advance       = 1'b1;
          if (w_last) begin
            cache_fill_last = 1'b1;
            w_next          = RESP;
          end
        end
      end
      RESP: begin
        rdata  = w_word;
        ready  = 1'b1;
        w_next = IDLE;
      end
      WRITE: begin
        sram_w_en    = 1'b1;
        sram_address = address;
        sram_wdata   = wdata;
        if (sram_ready) begin
          ready  = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && r_state == IDLE) begin
      assert (!(mem_r_en && mem_w_en))
        else $error("cache_line_ctrl: load and store requested together, load taken");
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;
  logic        w_hit_evt;
  logic        w_miss_evt;

  assign w_hit_evt  = (r_state == IDLE) && mem_r_en && cache_hit;
  assign w_miss_evt = (r_state == IDLE) && mem_r_en && !cache_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_hit_evt && r_hit_cnt != '1)   r_hit_cnt  <= r_hit_cnt + 32'd1;
      if (w_miss_evt && r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule
